// File: rtl/adc_par_capture.sv
// adc_par_capture: drives a parallel-output ADC clock, samples its data bus,
// waits for a level-crossing trigger, captures DEPTH samples into on-chip RAM
// and streams the frame out over a valid/ready interface.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   adc_clk         ADC conversion clock (registered, period CLK_DIV clks)
//   adc_db          ADC parallel data bus
//   start           arm request (1-cycle pulse, honoured only when idle)
//   trig_level      unsigned trigger threshold
//   trig_rise       1 = rising crossing, 0 = falling crossing
//   busy            high whenever not idle
//   done            1-cycle pulse after the final readout beat
//   rd_data/rd_valid/rd_ready/rd_last   frame readout stream
//   force_trig      (only with ADC_FORCE_TRIG_EN) arms an unconditional
//                   trigger on the next sample strobe while waiting
//
// Optional feature macro: ADC_FORCE_TRIG_EN
module adc_par_capture #(
  parameter int DATA_W  = 10,
  parameter int CLK_DIV = 4,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              adc_clk,
  input  logic [DATA_W-1:0] adc_db,
  input  logic              start,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rise,
`ifdef ADC_FORCE_TRIG_EN
  input  logic              force_trig,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READ} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                adc_clk_q, adc_clk_d;
  logic [DATA_W-1:0]   adc_q, adc_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                first_q, first_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;

  logic                s_stb;
  logic [DATA_W-1:0]   cur;
  logic                level_hit;
  logic                fire;
  logic                force_pend;
  logic                xfer;
  logic                fetch;

`ifdef ADC_FORCE_TRIG_EN
  logic force_pend_q, force_pend_d;
  assign force_pend = force_pend_q;
`else
  assign force_pend = 1'b0;
`endif

  assign s_stb = (div_cnt_q == DIV_MAX);
  assign cur   = adc_q;

  assign level_hit = trig_rise ? ((prev_q < trig_level) && (cur >= trig_level))
                               : ((prev_q > trig_level) && (cur <= trig_level));

  // The first strobe in WAIT_TRIG only primes prev; a pending force
  // overrides that and the level test.
  assign fire = s_stb && (force_pend || (!first_q && level_hit));

  assign xfer = rd_valid_q && rd_ready;
  // Refill the output register whenever it is empty or being drained,
  // except once the last sample is already sitting in it.
  assign fetch = (!rd_valid_q || rd_ready) && !(rd_valid_q && rd_last_q);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + 1'b1;
    adc_clk_d  = (div_cnt_q < DIV_HALF);
    adc_d      = adc_db;
    prev_d     = s_stb ? cur : prev_q;
    first_d    = first_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_TRIG;
          first_d = 1'b1;
        end
      end
      WAIT_TRIG: begin
        if (s_stb) first_d = 1'b0;
        if (fire) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_addr_d = ADDR_W'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (s_stb) begin
          mem_we = 1'b1;
          if (wr_addr_q == ADDR_MAX) begin
            state_d    = READ;
            rd_addr_d  = '0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      READ: begin
        if (fetch) begin
          rd_data_d  = mem[rd_addr_q];
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_addr_q == ADDR_MAX);
          rd_addr_d  = rd_addr_q + 1'b1;
        end else if (xfer) begin
          rd_valid_d = 1'b0;
        end
        if (xfer && rd_last_q) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ADC_FORCE_TRIG_EN
  always_comb begin
    force_pend_d = 1'b0;
    if (state_q == WAIT_TRIG && state_d == WAIT_TRIG)
      force_pend_d = force_pend_q || force_trig;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      adc_clk_q  <= 1'b0;
      adc_q      <= '0;
      prev_q     <= '0;
      first_q    <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
`ifdef ADC_FORCE_TRIG_EN
      force_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      adc_clk_q  <= adc_clk_d;
      adc_q      <= adc_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
`ifdef ADC_FORCE_TRIG_EN
      force_pend_q <= force_pend_d;
`endif
    end
  end

  // Frame RAM storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= cur;
  end

  assign adc_clk  = adc_clk_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_adc_par_capture.sv
// Directed testbench for adc_par_capture: table-driven reset/divider/start
// vectors plus hand-written capture, backpressure and abort sequences.
module tb_adc_par_capture;
  localparam int DATA_W = 10;

  logic              clk = 1'b0;
  logic              rst, start, trig_rise, rd_ready;
  logic [DATA_W-1:0] adc_db, trig_level;
  logic              adc_clk, busy, done, rd_valid, rd_last;
  logic [DATA_W-1:0] rd_data;
`ifdef ADC_FORCE_TRIG_EN
  logic              force_trig;
`endif

  adc_par_capture #(.DATA_W(10), .CLK_DIV(4), .DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .adc_clk(adc_clk), .adc_db(adc_db),
    .start(start), .trig_level(trig_level), .trig_rise(trig_rise),
`ifdef ADC_FORCE_TRIG_EN
    .force_trig(force_trig),
`endif
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] step;
  logic clk_prev = 1'b1;

  typedef struct {
    logic rst;
    logic start;
    logic exp_clk;
    logic exp_busy;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; afterwards the ADC model puts a new sample on the bus at each
  // rising adc_clk, like a real converter presenting data after its clock.
  task automatic tick();
    @(posedge clk);
    #1;
    if (adc_clk === 1'b1 && clk_prev === 1'b0) adc_db = adc_db + step;
    clk_prev = adc_clk;
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] exp0, input logic [DATA_W-1:0] estep,
                           input bit rnd, input bit do_start, input string tag);
    int t, k, cyc, bubbles;
    bit stalled;
    logic [DATA_W-1:0] held_data, exp_v;
    logic held_last;
    rd_ready = rnd ? 1'b0 : 1'b1;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);
    end
    t = 0;
    while (rd_valid !== 1'b1 && t < 3000) begin
      tick();
      t++;
    end
    check({tag, "_first_valid"}, rd_valid, 1);
    if (rd_valid !== 1'b1) return;
    k = 0; cyc = 0; bubbles = 0; stalled = 0;
    exp_v = exp0; held_data = '0; held_last = 1'b0;
    while (k < 256 && cyc < 5000) begin
      if (stalled) begin
        check({tag, "_stall_valid"}, rd_valid, 1);
        check({tag, "_stall_data"}, rd_data, held_data);
        check({tag, "_stall_last"}, rd_last, held_last);
      end
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rnd && rd_valid !== 1'b1) bubbles++;
      if (rd_valid === 1'b1 && rd_ready) begin
        check({tag, "_data"}, rd_data, exp_v);
        check({tag, "_last"}, rd_last, (k == 255) ? 1 : 0);
        exp_v = exp_v + estep;
        k++;
      end
      stalled   = (rd_valid === 1'b1) && !rd_ready;
      held_data = rd_data;
      held_last = rd_last;
      tick();
      cyc++;
    end
    rd_ready = 1'b0;
    check({tag, "_beats"}, k, 256);
    if (!rnd) check({tag, "_bubbles"}, bubbles, 0);
    check({tag, "_done_pulse"}, done, 1);
    check({tag, "_valid_after_last"}, rd_valid, 0);
    check({tag, "_idle_after_last"}, busy, 0);
    tick();
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, seen;
    rst = 1'b1; start = 1'b0; rd_ready = 1'b0;
    adc_db = '0; step = '0; trig_level = 10'd512; trig_rise = 1'b1;
`ifdef ADC_FORCE_TRIG_EN
    force_trig = 1'b0;
`endif

    // Reset, divider pattern 1,1,0,0 after release, start/rst interplay.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 15; i++) begin
      rst   = vecs[i].rst;
      start = vecs[i].start;
      tick();
      check($sformatf("vec%0d_adc_clk", i), adc_clk, vecs[i].exp_clk);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_rd_valid", i), rd_valid, 0);
      check($sformatf("vec%0d_done", i), done, 0);
      check($sformatf("vec%0d_rd_last", i), rd_last, 0);
      check($sformatf("vec%0d_rd_data", i), rd_data, 0);
    end
    start = 1'b0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;

    // Rising trigger on +8 ramp.
    adc_db = '0; step = 10'd8; trig_level = 10'd512; trig_rise = 1'b1;
    tick(); tick();
    run_frame(10'd512, 10'd8, 1'b0, 1'b1, "rise");

    // Falling trigger on -4 ramp from 1020.
    adc_db = 10'd1020; step = 10'h3FC; trig_level = 10'd600; trig_rise = 1'b0;
    tick();
    run_frame(10'd600, 10'h3FC, 1'b0, 1'b1, "fall");

    // Random backpressure.
    adc_db = '0; step = 10'd8; trig_level = 10'd512; trig_rise = 1'b1;
    tick();
    run_frame(10'd512, 10'd8, 1'b1, 1'b1, "bp");

    // Abort: start ignored mid-capture, rst at ~sample 100 of capture.
    adc_db = '0; step = 10'd8;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    t = 0;
    while (adc_db != 10'd512 && t < 2000) begin tick(); t++; end
    check("abort_ramp_reached_512", adc_db, 512);
    for (int i = 0; i < 200; i++) tick();
    start = 1'b1; tick(); start = 1'b0;
    check("abort_busy_after_ignored_start", busy, 1);
    for (int i = 0; i < 200; i++) tick();
    check("abort_busy_before_rst", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_busy_after_rst", busy, 0);
    check("abort_done_after_rst", done, 0);
    seen = 0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("abort_no_activity", seen, 0);
    run_frame(10'd512, 10'd8, 1'b0, 1'b1, "after_abort");

    // Constant input below level never triggers.
    adc_db = 10'd300; step = '0; trig_level = 10'd512; trig_rise = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (rd_valid !== 1'b0) seen++;
    end
    check("notrig_no_valid", seen, 0);
    check("notrig_still_waiting", busy, 1);
`ifdef ADC_FORCE_TRIG_EN
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    run_frame(10'd300, 10'd0, 1'b0, 1'b0, "force");
`else
    rst = 1'b1; tick(); rst = 1'b0;
    check("notrig_reset_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/adc_par_capture.md
Name: adc_par_capture

Overview:
- Receive-side counterpart of the parallel DAC driver: drives the clock of a parallel-output ADC and samples its data bus.
- Waits for a level-crossing trigger, then captures a frame of DEPTH samples into on-chip RAM.
- Streams the frame out over a valid/ready interface to user logic, such as a UART dump or a display.

Parameters:
- DATA_W, 10, ADC data bus width.
- CLK_DIV, 4, adc_clk period in clk cycles; even, >= 2.
- DEPTH, 256, samples per frame; power of two.
- ADDR_W, 8, log2(DEPTH).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; synchronous, active-high.
- adc_clk  out  1  ADC conversion clock.
- adc_db  in  DATA_W  ADC parallel data.
- start  in  1  arm request; 1-cycle pulse, honoured only in IDLE.
- trig_level  in  DATA_W  trigger threshold, unsigned.
- trig_rise  in  1  1 = rising-crossing trigger; 0 = falling-crossing trigger.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle pulse after the last readout beat.
- rd_data  out  DATA_W  frame sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  downstream accepts the beat.
- rd_last  out  1  high with the final sample, index DEPTH-1.

Behaviour:
- Clock and reset: reset is synchronous and active-high on rst. Single clock domain, clk.
- Reset values: adc_clk=0, busy=0, done=0, rd_valid=0, rd_last=0, rd_data=0, state=IDLE, div_cnt=0.
- rst asserted mid-operation aborts capture or readout. The frame is discarded and no done pulse is issued.
- Clock divider: div_cnt counts 0..CLK_DIV-1 and wraps, free-running in every state.
- adc_clk = 1 while div_cnt < CLK_DIV/2, else 0. adc_clk is registered.
- adc_db is registered every clk into adc_q.
- Sample strobe s_stb is high in the cycle where div_cnt == CLK_DIV-1. The sample value is adc_q in that cycle.
- prev holds the previous strobed sample. It is updated on every s_stb in every state.
- Trigger, unsigned compare:
  - Rising: prev < trig_level && cur >= trig_level.
  - Falling: prev > trig_level && cur <= trig_level.
  - The first strobe after entering WAIT_TRIG never triggers; it only loads prev.
- FSM states and transitions:
  - IDLE: start -> WAIT_TRIG.
  - WAIT_TRIG: on a trigger at s_stb, write cur to RAM[0], set wr_addr=1, -> CAPTURE.
  - CAPTURE: on each s_stb write cur to RAM[wr_addr] and increment wr_addr. The write at wr_addr == DEPTH-1 -> READ. No further writes; wr_addr does not wrap.
  - READ: rd_addr counts 0..DEPTH-1. Synchronous RAM read, 1-cycle latency.
    - rd_valid rises at most 2 cycles after entering READ.
    - rd_data, rd_valid and rd_last are held stable while rd_valid && !rd_ready.
    - A beat transfers on rd_valid && rd_ready.
    - rd_ready held high gives one beat per cycle, no bubbles.
    - The beat with rd_last transfers -> IDLE. done=1 for exactly that next cycle; rd_valid=0.
- start outside IDLE is ignored. start coincident with rst is ignored.
- trig_level and trig_rise are sampled live and may change during WAIT_TRIG.
- RAM: DEPTH x DATA_W, one write port and one read port. Written only during capture; read only during READ.

Optional Feature:
- Macro: ADC_FORCE_TRIG_EN.
- Defined:
  - Adds input port force_trig (1 bit).
  - In WAIT_TRIG, force_trig high on any cycle latches a pending flag.
  - The next s_stb acts as a trigger regardless of level, including the first strobe. The flag clears on leaving WAIT_TRIG or on rst.
- Undefined:
  - Port absent; only the level trigger applies.

Test Plan:
- Reset divider: rst for 3 cycles, then CLK_DIV=4 -> adc_clk=0 during reset; then pattern 1,1,0,0 repeating; s_stb every 4th cycle.
- Rising trigger on ramp: adc_db ramps +8 per ADC sample from 0, trig_level=512, trig_rise=1, start pulse -> frame[0]=512, frame[k]=512+8k; 256 beats; rd_last only on beat 255; done pulse one cycle after it.
- Falling trigger: ramp down from 1020 by 4, trig_level=600, trig_rise=0 -> frame[0] is the first sample <=600, i.e. 600.
- Backpressure: rd_ready toggles 1,0,0,1 randomly during READ -> no lost or duplicated beats; rd_data stable while stalled; exactly 256 transfers.
- Abort and ignore: start during CAPTURE ignored; rst asserted at sample 100 of CAPTURE -> busy=0 next cycle, no done, rd_valid never asserted; a new start works normally.
- ADC_FORCE_TRIG_EN: constant adc_db=300, trig_level=512, force_trig pulse -> capture begins at the next s_stb; 256 samples of 300 read out.
